// File: rtl/fft_pkg.sv
// Shared definitions for the FFT/IFFT stage blocks.
//   DW        : component width (signed two's complement)
//   NPTS      : transform size
//   complex_t : packed complex point, real in the low DW bits, imag in the high DW bits
//   ext_t     : DW+1-bit butterfly working width
//   pair_x/pair_rot : which points form butterfly pair p, and whether it uses the +j twiddle
//   sext/ext_add/ext_sub : widening arithmetic helpers shared by all stages
package fft_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned NPTS  = 8;
  localparam int unsigned NPAIR = NPTS / 2;
  localparam int unsigned CW    = 2 * DW;
  localparam int unsigned FW    = NPTS * CW;

  // Distance between the two inputs of a stage-2 butterfly (A/C, B/D, E/G, F/H)
  localparam int unsigned PAIR_SPAN = 2;

  typedef struct packed {
    logic signed [DW-1:0] im;
    logic signed [DW-1:0] re;
  } complex_t;

  typedef logic signed [DW:0] ext_t;

  // Pairs 0..3 take their first operand from points 0,1,4,5
  function automatic int unsigned pair_x(input int unsigned p);
    return (p / 2) * 4 + (p % 2);
  endfunction

  // Odd pairs (B/D, F/H) apply the conjugate twiddle +j
  function automatic logic pair_rot(input int unsigned p);
    return 1'(p % 2);
  endfunction

  function automatic ext_t sext(input logic signed [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  function automatic ext_t ext_add(input ext_t a, input ext_t b);
    return a + b;
  endfunction

  function automatic ext_t ext_sub(input ext_t a, input ext_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/ifft_bfly_pair.sv
// Combinational radix-2 butterfly: p = x + w*y, q = x - w*y, w in {1, +j}.
// Results are narrowed from DW+1 bits back to DW bits.
// Build option IFFT_STAGE2_SCALE_EN: halve with round-half-up instead of wrapping;
// overflow cannot occur then and ovf_c is 0.
//   x, y   : input points
//   rot    : 0 -> w = 1, 1 -> w = +j
//   p_c    : x + w*y
//   q_c    : x - w*y
//   ovf_c  : some result left the DW range (wrap build only)
module ifft_bfly_pair
  import fft_pkg::*;
(
  input  complex_t x,
  input  complex_t y,
  input  logic     rot,
  output complex_t p_c,
  output complex_t q_c,
  output logic     ovf_c
);

  ext_t wy_re;
  ext_t wy_im;
  ext_t p_re;
  ext_t p_im;
  ext_t q_re;
  ext_t q_im;

  // DW+1 -> DW narrowing
  function automatic logic signed [DW-1:0] narrow(input ext_t v);
`ifdef IFFT_STAGE2_SCALE_EN
    return DW'(({v[DW], v} + (DW+2)'(1)) >> 1);
`else
    return v[DW-1:0];
`endif
  endfunction

`ifndef IFFT_STAGE2_SCALE_EN
  // Top two bits differ -> value does not fit in DW bits
  function automatic logic out_of_range(input ext_t v);
    return v[DW] ^ v[DW-1];
  endfunction
`endif

  // Twiddle multiply and butterfly
  always_comb begin
    wy_re = sext(y.re);
    wy_im = sext(y.im);
    if (rot) begin
      // +j * (yr + j*yi) = -yi + j*yr; negating the most negative value still fits in DW+1
      wy_re = ext_sub('0, sext(y.im));
      wy_im = sext(y.re);
    end
    p_re = ext_add(sext(x.re), wy_re);
    p_im = ext_add(sext(x.im), wy_im);
    q_re = ext_sub(sext(x.re), wy_re);
    q_im = ext_sub(sext(x.im), wy_im);

    p_c    = '0;
    q_c    = '0;
    p_c.re = narrow(p_re);
    p_c.im = narrow(p_im);
    q_c.re = narrow(q_re);
    q_c.im = narrow(q_im);

`ifdef IFFT_STAGE2_SCALE_EN
    ovf_c = 1'b0;
`else
    ovf_c = out_of_range(p_re) | out_of_range(p_im) |
            out_of_range(q_re) | out_of_range(q_im);
`endif
  end

endmodule

// File: rtl/ifft_stage_2.sv
// Second radix-2 stage of the 8-point IFFT with valid/ready handshake and a
// one-entry skid buffer. One-cycle latency, one frame per cycle while m_ready=1.
// Build option IFFT_STAGE2_SCALE_EN: each result scaled by 1/2 (round-half-up), ovf stays 0.
//   clk, rst_n       : clock, asynchronous active-low reset
//   s_valid/s_ready  : input frame handshake (s_ready registered)
//   s_data           : 8 complex points, point k at [k*2*DW +: 2*DW], real low / imag high
//   m_valid/m_ready  : output frame handshake
//   m_data           : 8 complex results, same packing
//   ovf / ovf_clr    : sticky overflow flag and its synchronous clear (set wins)
// DW must equal fft_pkg::DW, which sizes complex_t.
module ifft_stage_2
  import fft_pkg::complex_t;
  import fft_pkg::NPTS;
  import fft_pkg::NPAIR;
  import fft_pkg::PAIR_SPAN;
  import fft_pkg::pair_x;
  import fft_pkg::pair_rot;
#(
  parameter int unsigned DW = fft_pkg::DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [16*DW-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [16*DW-1:0] m_data,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned FW = 16 * DW;

  complex_t            pts_in [NPTS];
  complex_t            res    [NPTS];
  logic [FW-1:0]       res_flat;
  logic [NPAIR-1:0]    pair_ovf;

  logic                accept;
  logic                take;

  logic                m_valid_nxt;
  logic [FW-1:0]       m_data_nxt;
  logic                skid_valid;
  logic                skid_valid_nxt;
  logic [FW-1:0]       skid_data;
  logic [FW-1:0]       skid_data_nxt;
  logic                s_ready_nxt;
  logic                ovf_nxt;

  // Unpack input points and repack results
  for (genvar k = 0; k < NPTS; k++) begin : g_pack
    assign pts_in[k]             = complex_t'(s_data[k*PW +: PW]);
    assign res_flat[k*PW +: PW]  = res[k];
  end

  // Four butterflies: A/C, B/D (+j), E/G, F/H (+j)
  for (genvar p = 0; p < NPAIR; p++) begin : g_bfly
    localparam int unsigned XI = pair_x(p);
    localparam int unsigned YI = XI + PAIR_SPAN;
    ifft_bfly_pair u_bfly (
      .x     (pts_in[XI]),
      .y     (pts_in[YI]),
      .rot   (pair_rot(p)),
      .p_c   (res[XI]),
      .q_c   (res[YI]),
      .ovf_c (pair_ovf[p])
    );
  end

  assign accept = s_valid & s_ready;
  assign take   = m_valid & m_ready;

  // Output register / skid steering; skid always drains before new data reaches the output
  always_comb begin
    m_valid_nxt    = m_valid;
    m_data_nxt     = m_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;

    if (take) begin
      if (skid_valid) begin
        // accept cannot coincide here: s_ready is low while skid is full
        m_data_nxt     = skid_data;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        m_data_nxt = res_flat;
      end else begin
        m_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      if (m_valid) begin
        skid_data_nxt  = res_flat;
        skid_valid_nxt = 1'b1;
      end else begin
        m_data_nxt  = res_flat;
        m_valid_nxt = 1'b1;
      end
    end

    s_ready_nxt = ~skid_valid_nxt;
    ovf_nxt     = (ovf & ~ovf_clr) | (accept & (|pair_ovf));
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      s_ready    <= 1'b1;
      ovf        <= 1'b0;
    end else begin
      m_valid    <= m_valid_nxt;
      m_data     <= m_data_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      s_ready    <= s_ready_nxt;
      ovf        <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_ifft_stage_2.sv
// Bench for ifft_stage_2: queue-based reference model plus directed literal checks.
module tb_ifft_stage_2;

  localparam int DW = 16;
  localparam int FW = 16 * DW;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [FW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [FW-1:0] m_data;
  logic          ovf;
  logic          ovf_clr;

  ifft_stage_2 #(.DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Narrow an exact result to a 16-bit component
  function automatic logic [15:0] fmt(input int v);
    int t;
`ifdef IFFT_STAGE2_SCALE_EN
    t = (v + 1) >>> 1;
`else
    t = v;
`endif
    return t[15:0];
  endfunction

  // Reference: exact integer butterflies on points A..H
  function automatic logic [FW-1:0] golden(input logic [FW-1:0] f, output logic ov);
    int re [8];
    int im [8];
    int ore[8];
    int oim[8];
    logic [FW-1:0] r;
    for (int k = 0; k < 8; k++) begin
      re[k] = int'($signed(f[k*32 +: 16]));
      im[k] = int'($signed(f[k*32+16 +: 16]));
    end
    for (int g = 0; g < 8; g += 4) begin
      ore[g]   = re[g] + re[g+2];    oim[g]   = im[g] + im[g+2];
      ore[g+2] = re[g] - re[g+2];    oim[g+2] = im[g] - im[g+2];
      ore[g+1] = re[g+1] - im[g+3];  oim[g+1] = im[g+1] + re[g+3];
      ore[g+3] = re[g+1] + im[g+3];  oim[g+3] = im[g+1] - re[g+3];
    end
    ov = 1'b0;
    r  = '0;
    for (int k = 0; k < 8; k++) begin
      r[k*32 +: 16]    = fmt(ore[k]);
      r[k*32+16 +: 16] = fmt(oim[k]);
`ifndef IFFT_STAGE2_SCALE_EN
      if (ore[k] > 32767 || ore[k] < -32768 || oim[k] > 32767 || oim[k] < -32768) ov = 1'b1;
`endif
    end
    return r;
  endfunction

  function automatic logic [31:0] cpx(input int re, input int im);
    logic [31:0] c;
    c[15:0]  = re[15:0];
    c[31:16] = im[15:0];
    return c;
  endfunction

  function automatic int fld(input int k, input bit imag);
    return int'($signed(m_data[k*32 + (imag ? 16 : 0) +: 16]));
  endfunction

  // Model: frames accepted and not yet delivered, in order
  logic [FW-1:0] q[$];
  logic          ovf_exp;
  logic          mov;
  logic [FW-1:0] mg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      ovf_exp = 1'b0;
    end else begin
      mg = golden(s_data, mov);
      if (m_valid && m_ready && q.size() > 0) begin
        void'(q.pop_front());
        n_out++;
      end
      if (s_valid && s_ready) q.push_back(mg);
      ovf_exp = (ovf_exp & ~ovf_clr) | (s_valid & s_ready & mov);
    end
  end

  // Compare every cycle: 0 frames -> idle, 1 -> output full, 2 -> skid full
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", FW'(m_valid), FW'(q.size() > 0));
      chk("s_ready", FW'(s_ready), FW'(q.size() < 2));
      chk("ovf", FW'(ovf), FW'(ovf_exp));
      if (m_valid && q.size() > 0) chk("m_data", m_data, q[0]);
    end
  end

  task automatic send(input logic [FW-1:0] f);
    bit acc;
    int n;
    s_valid = 1'b1;
    s_data  = f;
    n = 0;
    do begin
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    chk_int("send_accept", int'(acc), 1);
    s_valid = 1'b0;
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    logic [15:0]   v;
    int            s;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 0) v = 16'($urandom);
      else begin
        s = int'($urandom_range(0, 400)) - 200;
        v = s[15:0];
      end
      f[k*16 +: 16] = v;
    end
    return f;
  endfunction

  logic [FW-1:0] f0, f1, fo, g0, g1;
  logic          dummy;
  int            base, n_acc, cycles;
  bit            acc_now;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; ovf_clr = 1'b0;
    #12;
    chk("rst_m_valid", FW'(m_valid), FW'(0));
    chk("rst_s_ready", FW'(s_ready), FW'(1));
    chk("rst_ovf", FW'(ovf), FW'(0));
    chk("rst_m_data", m_data, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame
    f0 = '0;
    f0[0*32 +: 32] = cpx(100, 0);
    f0[2*32 +: 32] = cpx(20, 0);
    f0[3*32 +: 32] = cpx(3, 5);
    send(f0);
    chk_int("single_m_valid", int'(m_valid), 1);
`ifdef IFFT_STAGE2_SCALE_EN
    chk_int("A2r", fld(0, 0), 60); chk_int("A2i", fld(0, 1), 0);
    chk_int("C2r", fld(2, 0), 40); chk_int("C2i", fld(2, 1), 0);
    chk_int("B2r", fld(1, 0), -2); chk_int("B2i", fld(1, 1), 2);
    chk_int("D2r", fld(3, 0), 3);  chk_int("D2i", fld(3, 1), -1);
`else
    chk_int("A2r", fld(0, 0), 120); chk_int("A2i", fld(0, 1), 0);
    chk_int("C2r", fld(2, 0), 80);  chk_int("C2i", fld(2, 1), 0);
    chk_int("B2r", fld(1, 0), -5);  chk_int("B2i", fld(1, 1), 3);
    chk_int("D2r", fld(3, 0), 5);   chk_int("D2i", fld(3, 1), -3);
`endif
    chk("EFGH_zero", FW'(m_data[FW-1:128]), FW'(0));
    @(posedge clk); #1;
    chk_int("single_pulse", int'(m_valid), 0);

    // Streaming 10 back-to-back frames
    base = n_out;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = rand_frame();
      chk_int("stream_s_ready", int'(s_ready), 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("stream_count", n_out - base, 10);

    // Back-pressure: F0 in output, F1 in skid
    f0 = rand_frame();
    f1 = rand_frame();
    g0 = golden(f0, dummy);
    g1 = golden(f1, dummy);
    m_ready = 1'b0;
    send(f0);
    send(f1);
    chk_int("bp_s_ready_low", int'(s_ready), 0);
    chk("bp_hold_f0", m_data, g0);
    @(posedge clk); #1;
    chk("bp_stable_f0", m_data, g0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_then_f1", m_data, g1);
    chk_int("bp_s_ready_up", int'(s_ready), 1);
    @(posedge clk); #1;
    chk_int("bp_drained", int'(m_valid), 0);

    // Overflow and sticky clear
    fo = '0;
    fo[0*32 +: 32] = cpx(32767, 0);
    fo[2*32 +: 32] = cpx(1, 0);
    send(fo);
`ifdef IFFT_STAGE2_SCALE_EN
    chk_int("ovf_A2r", fld(0, 0), 16384);
    chk_int("ovf_set", int'(ovf), 0);
`else
    chk_int("ovf_A2r", fld(0, 0), -32768);
    chk_int("ovf_set", int'(ovf), 1);
`endif
    repeat (2) @(posedge clk);
    #1;
`ifdef IFFT_STAGE2_SCALE_EN
    chk_int("ovf_sticky", int'(ovf), 0);
`else
    chk_int("ovf_sticky", int'(ovf), 1);
`endif
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk_int("ovf_cleared", int'(ovf), 0);
    ovf_clr = 1'b1;
    send(fo);
    ovf_clr = 1'b0;
`ifdef IFFT_STAGE2_SCALE_EN
    chk_int("ovf_set_wins", int'(ovf), 0);
`else
    chk_int("ovf_set_wins", int'(ovf), 1);
`endif
    @(posedge clk); #1;

    // Reset with output and skid both full
    m_ready = 1'b0;
    send(fo);
    send(fo);
    chk_int("pre_rst_s_ready", int'(s_ready), 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_int("mid_rst_m_valid", int'(m_valid), 0);
    chk_int("mid_rst_s_ready", int'(s_ready), 1);
    chk_int("mid_rst_ovf", int'(ovf), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    base = n_out;
    repeat (4) @(posedge clk);
    #1;
    chk_int("post_rst_no_output", int'(m_valid), 0);

    // Random traffic with random back-pressure
    n_acc = 0;
    cycles = 0;
    while (n_acc < 10000 && cycles < 40000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      s_valid = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      s_data  = rand_frame();
      acc_now = s_valid & s_ready;
      @(posedge clk); #1;
      if (acc_now) n_acc++;
      cycles++;
    end
    chk_int("random_frames", n_acc, 10000);
    s_valid = 1'b0;
    ovf_clr = 1'b0;
    m_ready = 1'b1;
    cycles = 0;
    while (q.size() > 0 && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk_int("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
